game_ctrl: RTL

Game-flow controller for the basketball scoreboard. It sequences a game: four timed periods, a mm:ss game clock, a 24-second shot clock with automatic reloads, and buzzer windows on shot-clock violations and period ends. It sits between the debounce stage and the scoreboard/display logic and runs on the system clock. Slow timing arrives as a single-cycle `tick_1hz` enable.

---
 rtl/game_pkg.sv | 26 ++
 rtl/mmss_down_counter.sv | 53 +++++
 rtl/game_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and widths for the basketball game-flow controller.
package game_pkg;

   localparam int unsigned MIN_W  = 4;
   localparam int unsigned SEC_W  = 6;
   localparam int unsigned SHOT_W = 5;
   localparam int unsigned PER_W  = 3;
   localparam int unsigned TOT_W  = 10;

   localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

   typedef enum logic [2:0] {
      StIdle      = 3'd0,
      StRun       = 3'd1,
      StPause     = 3'd2,
      StShotViol  = 3'd3,
      StPeriodEnd = 3'd4,
      StGameOver  = 3'd5
   } game_state_t;

   function automatic logic [TOT_W-1:0] mmss_total(input logic [MIN_W-1:0] m,
                                                   input logic [SEC_W-1:0] s);
      return TOT_W'(m) * TOT_W'(60) + TOT_W'(s);
   endfunction

endpackage

// File: rtl/mmss_down_counter.sv
// mm:ss down counter for the game clock; stops at 0:00, reloads to load_min:00.
module mmss_down_counter
   import game_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [MIN_W-1:0] load_min,
   input  logic             en,
   input  logic             dec,
   output logic [MIN_W-1:0] min,
   output logic [SEC_W-1:0] sec,
   output logic             zero
);

   logic [MIN_W-1:0] min_q, min_d;
   logic [SEC_W-1:0] sec_q, sec_d;
   logic             at_zero;

   assign at_zero = (min_q == '0) && (sec_q == '0);

   always_comb begin
      min_d = min_q;
      sec_d = sec_q;
      if (load) begin
         min_d = load_min;
         sec_d = '0;
      end else if (en && dec && !at_zero) begin
         if (sec_q == '0) begin
            sec_d = SEC_MAX;
            min_d = min_q - MIN_W'(1);
         end else begin
            sec_d = sec_q - SEC_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         min_q <= load_min;
         sec_q <= '0;
      end else begin
         min_q <= min_d;
         sec_q <= sec_d;
      end
   end

   assign min  = min_q;
   assign sec  = sec_q;
   // High in the cycle whose decrement lands on 0:00.
   assign zero = en && dec && !load && (min_q == '0) && (sec_q == SEC_W'(1));

endmodule

// File: rtl/game_ctrl.sv
// Game-flow controller: periods, mm:ss game clock, shot clock and buzzer windows.
module game_ctrl
   import game_pkg::*;
#(
   parameter int unsigned PERIOD_MIN  = 10,
   parameter int unsigned SHOT_SEC    = 24,
   parameter int unsigned NUM_PERIODS = 4,
   parameter int unsigned BUZZ_TICKS  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick_1hz,
   input  logic              start_stop,
   input  logic              score_evt,
   input  logic              poss_a,
   input  logic              poss_b,
   output logic [MIN_W-1:0]  game_min,
   output logic [SEC_W-1:0]  game_sec,
   output logic [SHOT_W-1:0] shot_clock,
   output logic              shot_blank,
   output logic [PER_W-1:0]  period,
   output logic              running,
   output logic              buzzer,
   output logic [2:0]        state
);

   localparam int unsigned BUZZ_W = $clog2(BUZZ_TICKS + 1);
   localparam logic [SHOT_W-1:0] SHOT_RELOAD = SHOT_W'(SHOT_SEC);
   localparam logic [MIN_W-1:0]  MIN_RELOAD  = MIN_W'(PERIOD_MIN);
   localparam logic [PER_W-1:0]  PER_LAST    = PER_W'(NUM_PERIODS);
   localparam logic [BUZZ_W-1:0] BUZZ_LOAD   = BUZZ_W'(BUZZ_TICKS);

   game_state_t       state_q, state_d;
   logic [SHOT_W-1:0] shot_q, shot_d, shot_dec;
   logic [PER_W-1:0]  period_q, period_d;
   logic [BUZZ_W-1:0] buzz_q, buzz_d;
   logic [1:0]        poss_q;
   logic              running_q, buzzer_q, blank_q;
   logic              gc_en, gc_load, gc_zero, reload;
   logic [TOT_W-1:0]  gtot_q, gtot_d;

   assign gc_en    = (state_q == StRun);
   assign reload   = score_evt || (poss_q != {poss_b, poss_a});
   assign shot_dec = (shot_q != '0) ? shot_q - SHOT_W'(1) : '0;

   mmss_down_counter u_game_clk (
      .clk      (clk),
      .rst      (rst),
      .load     (gc_load),
      .load_min (MIN_RELOAD),
      .en       (gc_en),
      .dec      (tick_1hz),
      .min      (game_min),
      .sec      (game_sec),
      .zero     (gc_zero)
   );

   always_comb begin
      state_d  = state_q;
      shot_d   = shot_q;
      period_d = period_q;
      buzz_d   = buzz_q;
      gc_load  = 1'b0;
      case (state_q)
         StIdle: if (start_stop) state_d = StRun;
         StRun: begin
            // Expiry outranks start_stop and reload; game expiry outranks shot.
            if (tick_1hz && gc_zero) begin
               state_d = StPeriodEnd;
               buzz_d  = BUZZ_LOAD;
               shot_d  = shot_dec;
            end else if (tick_1hz && shot_q <= SHOT_W'(1)) begin
               state_d = StShotViol;
               buzz_d  = BUZZ_LOAD;
               shot_d  = '0;
            end else begin
               if (start_stop) state_d = StPause;
               if (reload) shot_d = SHOT_RELOAD;
               else if (tick_1hz) shot_d = shot_dec;
            end
         end
         StPause: begin
            if (start_stop) state_d = StRun;
            if (reload) shot_d = SHOT_RELOAD;
         end
         StShotViol: begin
            if (tick_1hz) begin
               buzz_d = buzz_q - BUZZ_W'(1);
               if (buzz_q <= BUZZ_W'(1)) begin
                  shot_d  = SHOT_RELOAD;
                  state_d = StPause;
               end
            end
         end
         StPeriodEnd: begin
            if (tick_1hz) begin
               buzz_d = buzz_q - BUZZ_W'(1);
               if (buzz_q <= BUZZ_W'(1)) begin
                  if (period_q == PER_LAST) begin
                     state_d = StGameOver;
                  end else begin
                     period_d = period_q + PER_W'(1);
                     gc_load  = 1'b1;
                     shot_d   = SHOT_RELOAD;
                     state_d  = StPause;
                  end
               end
            end
         end
         StGameOver: ;
         default: state_d = StIdle;
      endcase
   end

   // Next-state game total mirrors the counter so shot_blank lines up with it.
   assign gtot_q = mmss_total(game_min, game_sec);

   always_comb begin
      gtot_d = gtot_q;
      if (gc_load) gtot_d = mmss_total(MIN_RELOAD, '0);
      else if (gc_en && tick_1hz && gtot_q != '0) gtot_d = gtot_q - TOT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         shot_q    <= SHOT_RELOAD;
         period_q  <= PER_W'(1);
         buzz_q    <= '0;
         poss_q    <= {poss_b, poss_a};
         running_q <= 1'b0;
         buzzer_q  <= 1'b0;
         blank_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         shot_q    <= shot_d;
         period_q  <= period_d;
         buzz_q    <= buzz_d;
         poss_q    <= {poss_b, poss_a};
         running_q <= (state_d == StRun);
         buzzer_q  <= (state_d == StShotViol) || (state_d == StPeriodEnd);
         blank_q   <= gtot_d < TOT_W'(shot_d);
      end
   end

   assign shot_clock = shot_q;
   assign shot_blank = blank_q;
   assign period     = period_q;
   assign running    = running_q;
   assign buzzer     = buzzer_q;
   assign state      = state_q;

endmodule
